// File: rtl/instruction_fetch.sv
// Instruction fetch stage: sequential word fetch with a one-entry skid buffer,
// stall back-pressure and redirect handling (drains an in-flight request first).
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   pending_pc_q, pending_pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic              skid_valid_q, skid_valid_d;

  logic              consume_c;
  logic [XLEN-1:0]   redirect_tgt_c;

  assign consume_c      = instr_valid_q && !stall;
  assign redirect_tgt_c = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      pending_pc_q  <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      skid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      fetch_pc_q    <= fetch_pc_d;
      pending_pc_q  <= pending_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pending_pc_d  = pending_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    skid_valid_d  = skid_valid_q;

    if (redirect_valid) begin
      instr_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
      // An un-acked request must complete before the new target can be issued.
      if ((state_q == DRAIN) || ((state_q == FETCH) && !imem_ack)) begin
        pending_pc_d = redirect_tgt_c;
        state_d      = DRAIN;
      end else begin
        fetch_pc_d = redirect_tgt_c;
        state_d    = FETCH;
      end
    end else begin
      if (consume_c) begin
        instr_valid_d = 1'b0;
      end
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (!instr_valid_q || consume_c) begin
              instr_d       = imem_rdata;
              instr_pc_d    = fetch_pc_q;
              instr_valid_d = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = fetch_pc_q;
              skid_valid_d = 1'b1;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (consume_c) begin
            instr_d       = skid_instr_q;
            instr_pc_d    = skid_pc_q;
            instr_valid_d = 1'b1;
            skid_valid_d  = 1'b0;
            state_d       = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            fetch_pc_d = pending_pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized stall/redirect/ack traffic checked against a word-flow model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: count of fetched-but-unconsumed words, next pc to leave the stage,
  // next useful fetch address, and an outstanding discarded request.
  int          buffered;
  bit          draining;
  bit          idle;
  logic [31:0] drain_addr;
  logic [31:0] next_fetch;
  logic [31:0] exp_pc;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit exp_req_f();
    return !idle && (draining || (buffered < 2));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at a falling edge: checks outputs, drives inputs, advances one cycle.
  task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input bit ack);
    bit          m_req;
    bit          cons;
    bit          useful;
    logic [31:0] tgt;
    m_req = exp_req_f();
    check_eq("req", 32'(imem_req), 32'(m_req));
    if (m_req) check_eq("addr", imem_addr, draining ? drain_addr : next_fetch);
    check_eq("valid", 32'(instr_valid), 32'(buffered > 0));
    if (instr_valid) begin
      check_eq("pc", instr_pc, exp_pc);
      check_eq("data", instr, mem_word(instr_pc));
    end
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = ack;
    imem_rdata     = imem_req ? mem_word(imem_addr) : $urandom;
    cons   = (buffered > 0) && !st;
    useful = m_req && ack && !draining && !rv;
    tgt    = rpc & 32'hFFFF_FFFC;
    if (rv) begin
      if (!draining && m_req && !ack) begin
        draining   = 1'b1;
        drain_addr = next_fetch;
      end
      buffered   = 0;
      next_fetch = tgt;
      exp_pc     = tgt;
    end else begin
      if (draining && ack) draining = 1'b0;
      if (cons) begin
        buffered--;
        exp_pc = exp_pc + 32'd4;
      end
      if (useful) begin
        buffered++;
        next_fetch = next_fetch + 32'd4;
      end
    end
    idle = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted dly after a falling edge, checked asynchronously, released at the next falling edge.
  task automatic do_reset(input int dly);
    #(dly);
    rst_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, RESET_PC);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_pc", instr_pc, 32'd0);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    buffered   = 0;
    draining   = 1'b0;
    idle       = 1'b1;
    drain_addr = RESET_PC;
    next_fetch = RESET_PC;
    exp_pc     = RESET_PC;
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    @(negedge clk);
    do_reset(2);

    // Zero-wait streaming, then stall while 0x10 is acked.
    step(0, 0, 0, 1);
    for (int i = 0; i < 20 && imem_addr != 32'h10; i++) step(0, 0, 0, 1);
    check_eq("reach_0x10", imem_addr, 32'h10);
    step(1, 0, 0, 1);
    check_eq("hold_req", 32'(imem_req), 32'd0);
    check_eq("hold_pc", instr_pc, 32'h0C);
    step(0, 0, 0, 0);
    check_eq("skid_pc", instr_pc, 32'h10);
    check_eq("after_hold_req", 32'(imem_req), 32'd1);
    check_eq("after_hold_addr", imem_addr, 32'h14);

    // Redirect during a two-cycle fetch of 0x20.
    for (int i = 0; i < 20 && imem_addr != 32'h20; i++) step(0, 0, 0, 1);
    check_eq("reach_0x20", imem_addr, 32'h20);
    step(0, 1, 32'h200, 0);
    check_eq("drain_addr", imem_addr, 32'h20);
    check_eq("drain_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 0);
    check_eq("drain_addr2", imem_addr, 32'h20);
    step(0, 0, 0, 1);
    check_eq("redir_addr", imem_addr, 32'h200);
    check_eq("discard_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check_eq("redir_pc", instr_pc, 32'h200);

    // Redirect with stall and a full skid.
    step(1, 0, 0, 1);
    check_eq("skid_full_req", 32'(imem_req), 32'd0);
    step(1, 1, 32'h103, 0);
    check_eq("flush_valid", 32'(instr_valid), 32'd0);
    check_eq("flush_addr", imem_addr, 32'h100);

    // Address wrap.
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    check_eq("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    check_eq("wrap_pc1", instr_pc, 32'h0000_0000);

    // Reset while draining.
    step(0, 1, 32'h300, 0);
    step(0, 0, 0, 0);
    check_eq("pre_rst_drain", 32'(imem_req), 32'd1);
    do_reset(2);
    step(0, 0, 0, 1);
    check_eq("post_rst_req", 32'(imem_req), 32'd1);
    check_eq("post_rst_addr", imem_addr, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (($urandom % 1000) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        step(($urandom % 10) < 3, ($urandom % 25) == 0, $urandom, ($urandom % 10) < 6);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] SHALL be 0).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  downstream cannot accept; hold instr/instr_pc/instr_valid.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-006 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-009 SHALL have port imem_ack  input  1  memory returns data this cycle; ignored while imem_req=0.
REQ-010 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-011 SHALL have port instr_valid  output  1  instr holds a live instruction.
REQ-012 SHALL have port instr  output  32  fetched word; drives the decode stage's 32-bit instruction input.
REQ-013 SHALL have port instr_pc  output  32  address of instr.

Function
REQ-014 SHALL implement states IDLE, FETCH, HOLD, DRAIN; imem_req=1 exactly in FETCH and DRAIN, decoded from state only (no combinational path from any input).
REQ-015 SHALL keep imem_addr (fetch_pc register) and imem_req stable from assertion until the cycle imem_ack=1; zero-wait (ack in first req cycle) and multi-cycle acks both supported.
REQ-016 SHALL define "consume" as an edge with instr_valid=1 and stall=0.
REQ-017 SHALL contain one internal skid entry (skid_instr, skid_pc, skid_valid) holding one acked word while the output is stalled.
REQ-018 IDLE: SHALL move to FETCH on the next edge unconditionally.
REQ-019 FETCH with imem_ack=1 and no redirect: if output empty or consumed, SHALL load instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1; else SHALL load skid entry; fetch_pc<=fetch_pc+4.
REQ-020 After REQ-019, next state SHALL be HOLD if skid_valid becomes 1, else FETCH.
REQ-021 HOLD: imem_req=0; on consume SHALL move skid into instr/instr_pc (instr_valid stays 1), clear skid_valid, go to FETCH.
REQ-022 On consume with no replacement word (no ack, skid empty) SHALL clear instr_valid.
REQ-023 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Redirect (redirect_valid=1 at edge) SHALL have priority over stall, ack and consume, and SHALL clear instr_valid and skid_valid.
REQ-025 Redirect in FETCH with imem_ack=0: SHALL store target in pending_pc, keep fetch_pc, go to DRAIN.
REQ-026 Redirect in IDLE, HOLD, or FETCH with imem_ack=1: SHALL discard returned data, set fetch_pc<=redirect_pc, go to FETCH.
REQ-027 DRAIN: SHALL keep requesting old fetch_pc; on imem_ack SHALL discard data, fetch_pc<=pending_pc, go to FETCH; redirect in DRAIN SHALL overwrite pending_pc and stay in DRAIN.
REQ-028 A discarded word SHALL never appear on instr or set instr_valid.
REQ-029 Instructions SHALL exit in address order with no duplicates or losses absent redirect.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE, imem_req=0, imem_addr=RESET_PC, pending_pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, skid_valid=0.
REQ-031 Reset asserted mid-request or in DRAIN SHALL abandon the request; the first request after release SHALL be to RESET_PC, one cycle after IDLE.

Verification
REQ-032 Zero-wait memory, stall=0, release reset: imem_addr 0,4,8,...; instr_pc follows one cycle after each ack; instr_valid=1 continuously from first ack.
REQ-033 Ack at addr 0x10 with stall=1 and instr_valid=1 -> skid holds 0x10, state HOLD, imem_req=0; drop stall -> instr_pc=0x10 next edge, request 0x14 issued.
REQ-034 Two-cycle ack latency, redirect_pc=0x200 asserted in first wait cycle of fetch 0x20 -> imem_addr stays 0x20 until ack, data discarded, next request 0x200, first instr_pc=0x200.
REQ-035 redirect_valid and stall both 1 with skid full -> instr_valid=0, skid cleared, next request to redirect_pc; redirect_pc=0x103 -> fetch 0x100.
REQ-036 Redirect to 0xFFFF_FFFC, zero-wait -> instr_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-037 rst_n pulsed low during DRAIN -> outputs at reset values asynchronously; after release, first imem_addr=RESET_PC.
